// File: rtl/ex_stage_pkg.sv
// Shared widths, field layout and opcode constants for the execute stage.
// Also holds the store-lane helper.
package ex_stage_pkg;

    localparam int ID_TO_EX_WD  = 159;
    localparam int EX_TO_MEM_WD = 81;
    localparam int EX_TO_RF_WD  = 38;
    localparam int STALL_WD     = 6;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam logic [1:0] DIV_IDLE = 2'b00;
    localparam logic [1:0] DIV_BUSY = 2'b01;
    localparam logic [1:0] DIV_DONE = 2'b10;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_LB      = 6'b100000;
    localparam logic [5:0] OP_LBU     = 6'b100100;
    localparam logic [5:0] OP_LH      = 6'b100001;
    localparam logic [5:0] OP_LHU     = 6'b100101;
    localparam logic [5:0] OP_LW      = 6'b100011;

    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [11:0] alu_op;
        logic [2:0]  sel_alu_src1;
        logic [3:0]  sel_alu_src2;
        logic        data_ram_en;
        logic [3:0]  data_ram_wen;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic        sel_rf_res;
        logic [31:0] rdata1;
        logic [31:0] rdata2;
    } id_ex_t;

    // Store kind {0, sb, sh, sw} -> {byte write mask, lane-replicated data}.
    function automatic logic [35:0] store_lanes(input logic [3:0]  kind,
                                                input logic [1:0]  addr_lo,
                                                input logic [31:0] rt);
        logic [3:0]  wen;
        logic [31:0] wdata;
        case (kind)
            4'b0001: begin
                wen   = 4'b1111;
                wdata = rt;
            end
            4'b0010: begin
                wen   = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata = {2{rt[15:0]}};
            end
            4'b0100: begin
                wen   = 4'b0001 << addr_lo;
                wdata = {4{rt[7:0]}};
            end
            default: begin
                wen   = 4'b0000;
                wdata = 32'h0000_0000;
            end
        endcase
        return {wen, wdata};
    endfunction

endpackage

// File: rtl/ex_stage_div.sv
// Iterative restoring divider for div/divu: one quotient bit per cycle on
// operand magnitudes, signs reapplied once the iterations finish.
module div_iter
    import ex_stage_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        ack,
    input  logic        signed_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] quo,
    output logic [31:0] rem
);

    localparam int         CNT_W    = $clog2(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

    logic [1:0]       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [31:0]      quo_r;
    logic [31:0]      rem_r;
    logic [31:0]      dvs_r;
    logic [31:0]      dvd_r;
    logic             q_neg_r;
    logic             r_neg_r;
    logic             dvz_r;

    logic        a_neg_s;
    logic        b_neg_s;
    logic [31:0] a_mag_s;
    logic [31:0] b_mag_s;
    logic [32:0] rem_shift_s;
    logic [32:0] diff_s;

    assign a_neg_s = signed_op & a[31];
    assign b_neg_s = signed_op & b[31];
    assign a_mag_s = a_neg_s ? (32'd0 - a) : a;
    assign b_mag_s = b_neg_s ? (32'd0 - b) : b;

    // A set diff_s[32] means the trial subtraction went negative: restore.
    assign rem_shift_s = {rem_r, quo_r[31]};
    assign diff_s      = rem_shift_s - {1'b0, dvs_r};

    // Divider FSM, iteration counter and partial remainder/quotient.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= DIV_IDLE;
            cnt_r   <= '0;
            quo_r   <= 32'd0;
            rem_r   <= 32'd0;
            dvs_r   <= 32'd0;
            dvd_r   <= 32'd0;
            q_neg_r <= 1'b0;
            r_neg_r <= 1'b0;
            dvz_r   <= 1'b0;
        end else begin
            case (state_r)
                DIV_IDLE: begin
                    if (start) begin
                        state_r <= DIV_BUSY;
                        cnt_r   <= '0;
                        quo_r   <= a_mag_s;
                        rem_r   <= 32'd0;
                        dvs_r   <= b_mag_s;
                        dvd_r   <= a;
                        q_neg_r <= a_neg_s ^ b_neg_s;
                        r_neg_r <= a_neg_s;
                        dvz_r   <= (b == 32'd0);
                    end else begin
                        state_r <= DIV_IDLE;
                    end
                end
                DIV_BUSY: begin
                    if (!diff_s[32]) begin
                        rem_r <= diff_s[31:0];
                        quo_r <= {quo_r[30:0], 1'b1};
                    end else begin
                        rem_r <= rem_shift_s[31:0];
                        quo_r <= {quo_r[30:0], 1'b0};
                    end
                    cnt_r <= cnt_r + 1'b1;
                    if (cnt_r == CNT_LAST) begin
                        state_r <= DIV_DONE;
                    end else begin
                        state_r <= DIV_BUSY;
                    end
                end
                DIV_DONE: begin
                    if (ack) begin
                        state_r <= DIV_IDLE;
                    end else begin
                        state_r <= DIV_DONE;
                    end
                end
                default: begin
                    state_r <= DIV_IDLE;
                end
            endcase
        end
    end

    assign busy = ((state_r == DIV_IDLE) & start) | (state_r == DIV_BUSY);
    assign done = (state_r == DIV_DONE);
    assign quo  = dvz_r ? 32'hFFFF_FFFF : (q_neg_r ? (32'd0 - quo_r) : quo_r);
    assign rem  = dvz_r ? dvd_r : (r_neg_r ? (32'd0 - rem_r) : rem_r);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: decode-to-execute register, one-hot ALU, data-SRAM request,
// forwarding bus and the HI/LO registers with multiply and divide.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_WD-1:0]     stall,
    input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
    output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    output logic [EX_TO_RF_WD-1:0]  ex_to_rf_bus,
    output logic                    data_sram_en,
    output logic [3:0]              data_sram_wen,
    output logic [31:0]             data_sram_addr,
    output logic [31:0]             data_sram_wdata,
    output logic                    stallreq_for_ex
);

    id_ex_t      ex_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;

    // Decode-to-execute register: bubble, load or hold under the stall vector.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_r <= '0;
        end else if (stall[2] == STOP && stall[3] == NO_STOP) begin
            ex_r <= '0;
        end else if (stall[2] == NO_STOP) begin
            ex_r <= id_to_ex_bus;
        end else begin
            ex_r <= ex_r;
        end
    end

    logic [5:0] op_s;
    logic [5:0] funct_s;
    logic       special_s;
    logic       hilo_move_s;
    logic       is_mfhi_s, is_mflo_s, is_mthi_s, is_mtlo_s;
    logic       is_mult_s, is_multu_s, is_div_s, is_divu_s;

    assign op_s        = ex_r.inst[31:26];
    assign funct_s     = ex_r.inst[5:0];
    assign special_s   = (op_s == OP_SPECIAL);
    // mfhi/mflo require their unused rs/rt/sa fields to be zero.
    assign hilo_move_s = special_s & (ex_r.inst[25:16] == 10'd0) & (ex_r.inst[10:6] == 5'd0);
    assign is_mfhi_s   = hilo_move_s & (funct_s == FN_MFHI);
    assign is_mflo_s   = hilo_move_s & (funct_s == FN_MFLO);
    assign is_mthi_s   = special_s & (funct_s == FN_MTHI);
    assign is_mtlo_s   = special_s & (funct_s == FN_MTLO);
    assign is_mult_s   = special_s & (funct_s == FN_MULT);
    assign is_multu_s  = special_s & (funct_s == FN_MULTU);
    assign is_div_s    = special_s & (funct_s == FN_DIV);
    assign is_divu_s   = special_s & (funct_s == FN_DIVU);

    logic [31:0] src1_s;
    logic [31:0] src2_s;

    assign src1_s = ({32{ex_r.sel_alu_src1[0]}} & ex_r.rdata1)
                  | ({32{ex_r.sel_alu_src1[1]}} & ex_r.pc)
                  | ({32{ex_r.sel_alu_src1[2]}} & {27'd0, ex_r.inst[10:6]});

    assign src2_s = ({32{ex_r.sel_alu_src2[0]}} & ex_r.rdata2)
                  | ({32{ex_r.sel_alu_src2[1]}} & {{16{ex_r.inst[15]}}, ex_r.inst[15:0]})
                  | ({32{ex_r.sel_alu_src2[2]}} & 32'd8)
                  | ({32{ex_r.sel_alu_src2[3]}} & {16'd0, ex_r.inst[15:0]});

    logic [11:0] aop_s;
    logic [4:0]  sh_amt_s;
    logic        slt_s;
    logic        sltu_s;
    logic [31:0] alu_res_s;
    logic [31:0] ex_result_s;

    assign aop_s    = ex_r.alu_op;
    assign sh_amt_s = src1_s[4:0];
    assign slt_s    = ($signed(src1_s) < $signed(src2_s));
    assign sltu_s   = (src1_s < src2_s);

    assign alu_res_s = ({32{aop_s[11]}} & (src1_s + src2_s))
                     | ({32{aop_s[10]}} & (src1_s - src2_s))
                     | ({32{aop_s[9]}}  & {31'd0, slt_s})
                     | ({32{aop_s[8]}}  & {31'd0, sltu_s})
                     | ({32{aop_s[7]}}  & (src1_s & src2_s))
                     | ({32{aop_s[6]}}  & ~(src1_s | src2_s))
                     | ({32{aop_s[5]}}  & (src1_s | src2_s))
                     | ({32{aop_s[4]}}  & (src1_s ^ src2_s))
                     | ({32{aop_s[3]}}  & (src2_s << sh_amt_s))
                     | ({32{aop_s[2]}}  & (src2_s >> sh_amt_s))
                     | ({32{aop_s[1]}}  & 32'($signed(src2_s) >>> sh_amt_s))
                     | ({32{aop_s[0]}}  & {src2_s[15:0], 16'd0});

    assign ex_result_s = is_mfhi_s ? hi_r : (is_mflo_s ? lo_r : alu_res_s);

    logic [35:0] lanes_s;
    logic [4:0]  mem_ld_s;

    assign lanes_s  = ex_r.data_ram_en
                    ? store_lanes(ex_r.data_ram_wen, ex_result_s[1:0], ex_r.rdata2)
                    : 36'd0;
    assign mem_ld_s = {op_s == OP_LB, op_s == OP_LBU, op_s == OP_LH, op_s == OP_LHU, op_s == OP_LW};

    assign data_sram_en    = ex_r.data_ram_en;
    assign data_sram_wen   = lanes_s[35:32];
    assign data_sram_addr  = ex_result_s;
    assign data_sram_wdata = lanes_s[31:0];

    assign ex_to_mem_bus = {ex_r.pc, mem_ld_s, ex_r.data_ram_en, ex_r.data_ram_wen,
                            ex_r.sel_rf_res, ex_r.rf_we, ex_r.rf_waddr, ex_result_s};
    assign ex_to_rf_bus  = {ex_r.rf_we, ex_r.rf_waddr, ex_result_s};

    // Sign-extending both operands lets one 64-bit multiplier cover mult and multu.
    logic [63:0] mul_a_s;
    logic [63:0] mul_b_s;
    logic [63:0] prod_s;

    assign mul_a_s = {{32{is_mult_s & ex_r.rdata1[31]}}, ex_r.rdata1};
    assign mul_b_s = {{32{is_mult_s & ex_r.rdata2[31]}}, ex_r.rdata2};
    assign prod_s  = mul_a_s * mul_b_s;

    logic        div_busy_s;
    logic        div_done_s;
    logic [31:0] div_quo_s;
    logic [31:0] div_rem_s;

    div_iter #(
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (is_div_s | is_divu_s),
        .ack       (stall[3] == NO_STOP),
        .signed_op (is_div_s),
        .a         (ex_r.rdata1),
        .b         (ex_r.rdata2),
        .busy      (div_busy_s),
        .done      (div_done_s),
        .quo       (div_quo_s),
        .rem       (div_rem_s)
    );

    assign stallreq_for_ex = div_busy_s;

    // HI/LO update, only on edges where the stage after execute advances.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hi_r <= 32'd0;
            lo_r <= 32'd0;
        end else if (stall[3] == NO_STOP) begin
            if (div_done_s) begin
                hi_r <= div_rem_s;
                lo_r <= div_quo_s;
            end else if (is_mult_s | is_multu_s) begin
                hi_r <= prod_s[63:32];
                lo_r <= prod_s[31:0];
            end else if (is_mthi_s) begin
                hi_r <= ex_r.rdata1;
            end else if (is_mtlo_s) begin
                lo_r <= ex_r.rdata1;
            end else begin
                hi_r <= hi_r;
                lo_r <= lo_r;
            end
        end else begin
            hi_r <= hi_r;
            lo_r <= lo_r;
        end
    end

endmodule
